systolic_sequencer: RTL and testbench

SYSTOLIC_SEQUENCER -- requirements
Module: systolic_sequencer

---
 rtl/systolic_pkg.sv | 37 +++
 rtl/systolic_sequencer.sv | 122 ++++++++++++
 tb/tb_systolic_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : systolic_pkg
// Purpose  : Shared state encoding and sizing helpers for the systolic array
//            sequencer, reusable by the array top and its bench.
// Revision : 1.0 - initial release
// ============================================================================
package systolic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_FEED    = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_READOUT = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // Cycles from the last operand fed until the far-corner PE has its result:
  // skew propagation across both axes, one hop, plus the MAC pipeline.
  function automatic int drain_len(input int n, input int lat);
    return 2 * (n - 1) + 1 + lat;
  endfunction

  // Shared counter width; drain_len always exceeds n, so this covers FEED
  // and READOUT counts as well.
  function automatic int cnt_width(input int n, input int lat);
    return $clog2(drain_len(n, lat) + 1);
  endfunction

  // Operand / row index width, at least one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage : systolic_pkg
`default_nettype wire

// File: rtl/systolic_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : systolic_sequencer
// Purpose  : Control FSM for an NxN systolic matrix multiply: clears the PEs,
//            streams N operand indices, waits for the array to drain, then
//            hands result rows out over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_sequencer
  import systolic_pkg::*;
#(
  parameter  int MATRIX_SIZE = 2,
  parameter  int PE_LATENCY  = 1,
  localparam int IDXW        = idx_width(MATRIX_SIZE)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [IDXW-1:0] rd_idx,
  output logic            feed_valid,
  output logic            skew_enable,
  output logic            pe_clear,
  output logic            pe_enable,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IDXW-1:0] out_row
);

  localparam int D  = drain_len(MATRIX_SIZE, PE_LATENCY);
  localparam int CW = cnt_width(MATRIX_SIZE, PE_LATENCY);

  localparam logic [CW-1:0] LAST_IDX   = CW'(MATRIX_SIZE - 1);
  localparam logic [CW-1:0] LAST_DRAIN = CW'(D - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            feed_valid_q;

  // State and shared counter; the counter restarts at zero on every state
  // entry so FEED, DRAIN and READOUT each count from the beginning.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      feed_valid_q <= 1'b0;
    end else begin
      // Operand data lags the read strobe by the buffer latency; a cancel
      // suppresses the trailing beat so nothing is strobed after abort.
      feed_valid_q <= (state == ST_FEED) && !abort;
      if (abort && (state != ST_IDLE)) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            cnt <= '0;
            if (start) state <= ST_CLEAR;
          end
          ST_CLEAR: begin
            state <= ST_FEED;
            cnt   <= '0;
          end
          ST_FEED: begin
            if (cnt == LAST_IDX) begin
              state <= ST_DRAIN;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_DRAIN: begin
            if (cnt == LAST_DRAIN) begin
              state <= ST_READOUT;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_READOUT: begin
            if (out_ready) begin
              if (cnt == LAST_IDX) begin
                state <= ST_DONE;
                cnt   <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Output decode purely from registered state, so reset clears every
  // output immediately and no input reaches an output combinationally.
  always_comb begin
    busy        = (state != ST_IDLE);
    done        = (state == ST_DONE);
    pe_clear    = (state == ST_CLEAR);
    rd_en       = (state == ST_FEED);
    rd_idx      = rd_en ? cnt[IDXW-1:0] : '0;
    skew_enable = (state == ST_FEED) || (state == ST_DRAIN);
    pe_enable   = skew_enable;
    out_valid   = (state == ST_READOUT);
    out_row     = out_valid ? cnt[IDXW-1:0] : '0;
    feed_valid  = feed_valid_q;
  end

endmodule : systolic_sequencer
`default_nettype wire

// File: tb/tb_systolic_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_sequencer
// Purpose  : Scoreboard bench for systolic_sequencer at N=2/L=1 and N=4/L=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_sequencer;
  import systolic_pkg::*;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [1:0] rd_idx;
    logic       feed_valid;
    logic       skew;
    logic       clr;
    logic       pen;
    logic       ov;
    logic [1:0] row;
  } snap_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic start2 = 1'b0, abort2 = 1'b0, ready2 = 1'b1;
  logic busy2, done2, rd_en2, fv2, skew2, clr2, pen2, ov2;
  logic [0:0] idx2, row2;

  logic start4 = 1'b0, abort4 = 1'b0, ready4 = 1'b1;
  logic busy4, done4, rd_en4, fv4, skew4, clr4, pen4, ov4;
  logic [1:0] idx4, row4;

  systolic_sequencer #(.MATRIX_SIZE(2), .PE_LATENCY(1)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .abort(abort2),
    .busy(busy2), .done(done2), .rd_en(rd_en2), .rd_idx(idx2),
    .feed_valid(fv2), .skew_enable(skew2), .pe_clear(clr2),
    .pe_enable(pen2), .out_valid(ov2), .out_ready(ready2), .out_row(row2)
  );

  systolic_sequencer #(.MATRIX_SIZE(4), .PE_LATENCY(2)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .abort(abort4),
    .busy(busy4), .done(done4), .rd_en(rd_en4), .rd_idx(idx4),
    .feed_valid(fv4), .skew_enable(skew4), .pe_clear(clr4),
    .pe_enable(pen4), .out_valid(ov4), .out_ready(ready4), .out_row(row4)
  );

  always #5 clk = ~clk;

  snap_t exp2[$];
  snap_t exp4[$];
  snap_t e2, a2, e4, a4;
  int    vectors = 0;
  int    miscompares = 0;
  logic  chk_req = 1'b0;
  logic  to_req = 1'b0;

  function automatic snap_t act2();
    snap_t s;
    s = {busy2, done2, rd_en2, {1'b0, idx2}, fv2, skew2, clr2, pen2, ov2, {1'b0, row2}};
    return s;
  endfunction

  function automatic snap_t act4();
    snap_t s;
    s = {busy4, done4, rd_en4, idx4, fv4, skew4, clr4, pen4, ov4, row4};
    return s;
  endfunction

  // Monitor: per-cycle scoreboard compare, plus on-demand immediate checks.
  always @(negedge clk or posedge chk_req or posedge to_req) begin
    if (to_req) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout t=%0t actual=queues_not_drained required=drained", $time);
    end else if (chk_req) begin
      vectors++;
      a2 = act2();
      if (a2 !== '0) begin
        miscompares++;
        $display("FAIL async_reset_n2 t=%0t actual=%b required=%b", $time, a2, snap_t'(0));
      end
    end else begin
      if (exp2.size() != 0) begin
        e2 = exp2.pop_front();
        a2 = act2();
        vectors++;
        if (a2 !== e2) begin
          miscompares++;
          $display("FAIL n2_cycle t=%0t actual=%b required=%b", $time, a2, e2);
        end
      end
      if (exp4.size() != 0) begin
        e4 = exp4.pop_front();
        a4 = act4();
        vectors++;
        if (a4 !== e4) begin
          miscompares++;
          $display("FAIL n4_cycle t=%0t actual=%b required=%b", $time, a4, e4);
        end
      end
    end
  end

  // Expected per-cycle timeline of one operation, cycle 0 = start cycle.
  // stall: extra cycles row 0 waits; abort_at: cycle abort is high (-1 none).
  task automatic push_op(input int sel, input int n, input int d, input int stall,
                         input int abort_at, input int idle_after);
    snap_t tl[$];
    snap_t s;
    tl.push_back('0);
    s = '0; s.busy = 1'b1; s.clr = 1'b1; tl.push_back(s);
    for (int k = 0; k < n; k++) begin
      s = '0; s.busy = 1'b1; s.rd_en = 1'b1; s.rd_idx = 2'(k);
      s.skew = 1'b1; s.pen = 1'b1; s.feed_valid = (k > 0);
      tl.push_back(s);
    end
    for (int k = 0; k < d; k++) begin
      s = '0; s.busy = 1'b1; s.skew = 1'b1; s.pen = 1'b1; s.feed_valid = (k == 0);
      tl.push_back(s);
    end
    for (int r = 0; r < n; r++) begin
      for (int h = 0; h <= ((r == 0) ? stall : 0); h++) begin
        s = '0; s.busy = 1'b1; s.ov = 1'b1; s.row = 2'(r);
        tl.push_back(s);
      end
    end
    s = '0; s.busy = 1'b1; s.done = 1'b1; tl.push_back(s);
    for (int k = 0; k < idle_after; k++) tl.push_back('0);
    for (int i = 0; i < tl.size(); i++) begin
      if (abort_at >= 0 && i > abort_at + 1) break;
      s = (abort_at >= 0 && i == abort_at + 1) ? snap_t'(0) : tl[i];
      if (sel == 2) exp2.push_back(s);
      else          exp4.push_back(s);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty();
    int guard;
    guard = 0;
    while ((exp2.size() != 0 || exp4.size() != 0) && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 500) begin
      to_req = 1'b1;
      #1;
      to_req = 1'b0;
      exp2.delete();
      exp4.delete();
    end
  endtask

  initial begin
    // Reset state
    tick();
    repeat (3) begin
      exp2.push_back('0);
      exp4.push_back('0);
    end
    repeat (3) tick();
    reset = 1'b1;
    wait_empty();

    // Nominal N=2: clear@1, feed@2-3, drain@4-7, rows@8-9, done@10
    tick();
    push_op(2, 2, 4, 0, -1, 2);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    wait_empty();

    // Backpressure: out_ready low in cycles 8-10, done@13
    tick();
    push_op(2, 2, 4, 3, -1, 2);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    repeat (7) tick();
    ready2 = 1'b0;
    repeat (3) tick();
    ready2 = 1'b1;
    wait_empty();

    // Abort in DRAIN at cycle 5, restart at cycle 7
    tick();
    push_op(2, 2, 4, 0, 5, 0);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    repeat (4) tick();
    abort2 = 1'b1;
    tick();
    abort2 = 1'b0;
    tick();
    push_op(2, 2, 4, 0, -1, 2);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    wait_empty();

    // start held high: one operation per IDLE entry
    tick();
    push_op(2, 2, 4, 0, -1, 0);
    push_op(2, 2, 4, 0, -1, 3);
    start2 = 1'b1;
    repeat (13) tick();
    start2 = 1'b0;
    wait_empty();

    // Asynchronous reset mid-FEED
    tick();
    exp2.push_back('0);
    begin
      snap_t s;
      s = '0; s.busy = 1'b1; s.clr = 1'b1;
      exp2.push_back(s);
    end
    repeat (20) exp2.push_back('0);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk_req = 1'b1;
    #1;
    chk_req = 1'b0;
    tick();
    tick();
    #3;
    reset = 1'b1;
    wait_empty();

    // N=4, L=2: feed 4, drain 9, 4 rows
    tick();
    push_op(4, 4, 9, 0, -1, 2);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    wait_empty();

    // N=4 with row 0 stalled two cycles
    tick();
    push_op(4, 4, 9, 2, -1, 2);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    repeat (14) tick();
    ready4 = 1'b0;
    repeat (2) tick();
    ready4 = 1'b1;
    wait_empty();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_systolic_sequencer
`default_nettype wire
